// File: rtl/addsub_seq_unit.sv
// Multi-cycle two's-complement adder/subtractor: one CHUNK-bit carry slice reused
// NCHUNK times per operation, with valid/ready on both sides. Optional macro: ADDSUB_SAT_EN.
module addsub_seq_unit #(
    parameter int WIDTH = 8,
    parameter int CHUNK = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_in_valid,
    output logic             o_in_ready,
    input  logic             i_mode,
    input  logic [WIDTH-1:0] i_a,
    input  logic [WIDTH-1:0] i_b,
    output logic             o_out_valid,
    input  logic             i_out_ready,
    output logic [WIDTH-1:0] o_s,
    output logic             o_cout,
    output logic             o_ovf,
    output logic             o_zero
);

    localparam int NCHUNK = WIDTH / CHUNK;
    localparam int IDXW   = (NCHUNK > 1) ? $clog2(NCHUNK) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NCHUNK - 1);

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN  = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    state_t           r_state;
    state_t           w_state_next;
    logic             r_in_ready;
    logic             r_out_valid;

    logic [WIDTH-1:0] r_a;
    logic [WIDTH-1:0] r_b;
    logic [WIDTH-1:0] r_res;
    logic             r_carry;
    logic [IDXW-1:0]  r_idx;

    logic [WIDTH-1:0] r_s;
    logic             r_cout;
    logic             r_ovf;
    logic             r_zero;

    logic             w_accept;
    logic             w_last;
    logic [CHUNK-1:0] w_a_chunk;
    logic [CHUNK-1:0] w_b_chunk;
    logic [CHUNK:0]   w_chunk_full;
    logic [CHUNK-1:0] w_sum_chunk;
    logic             w_chunk_cout;
    logic             w_chunk_cmsb;
    logic             w_ovf_final;
    logic [WIDTH-1:0] w_res_next;
    logic [WIDTH-1:0] w_s_final;

`ifdef ADDSUB_SAT_EN
    // Signed extreme in the direction of operand A's sign.
    function automatic logic [WIDTH-1:0] sat_value(input logic a_msb);
        logic [WIDTH-1:0] v;
        if (a_msb) begin
            v = {1'b1, {(WIDTH-1){1'b0}}};
        end else begin
            v = {1'b0, {(WIDTH-1){1'b1}}};
        end
        return v;
    endfunction
`endif

    assign w_accept = i_in_valid && r_in_ready;
    assign w_last   = (r_state == ST_RUN) && (r_idx == LAST_IDX);

    // Single carry-chain slice operating on the current chunk.
    always_comb begin
        w_a_chunk    = r_a[int'(r_idx)*CHUNK +: CHUNK];
        w_b_chunk    = r_b[int'(r_idx)*CHUNK +: CHUNK];
        w_chunk_full = {1'b0, w_a_chunk} + {1'b0, w_b_chunk} + {{CHUNK{1'b0}}, r_carry};
        w_sum_chunk  = w_chunk_full[CHUNK-1:0];
        w_chunk_cout = w_chunk_full[CHUNK];
        // Carry into the slice MSB recovered from the sum bit and its two addend bits.
        w_chunk_cmsb = w_sum_chunk[CHUNK-1] ^ w_a_chunk[CHUNK-1] ^ w_b_chunk[CHUNK-1];
        w_ovf_final  = w_chunk_cmsb ^ w_chunk_cout;
    end

    // Merge the new sum chunk into the partial result and apply optional clamping.
    always_comb begin
        w_res_next = r_res;
        w_res_next[int'(r_idx)*CHUNK +: CHUNK] = w_sum_chunk;
`ifdef ADDSUB_SAT_EN
        if (w_ovf_final) begin
            w_s_final = sat_value(r_a[WIDTH-1]);
        end else begin
            w_s_final = w_res_next;
        end
`else
        w_s_final = w_res_next;
`endif
    end

    // Next-state logic.
    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_accept) begin
                    w_state_next = ST_RUN;
                end else begin
                    w_state_next = ST_IDLE;
                end
            end
            ST_RUN: begin
                if (w_last) begin
                    w_state_next = ST_DONE;
                end else begin
                    w_state_next = ST_RUN;
                end
            end
            ST_DONE: begin
                if (i_out_ready) begin
                    w_state_next = ST_IDLE;
                end else begin
                    w_state_next = ST_DONE;
                end
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    // State register with registered handshake outputs decoded from the next state.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_IDLE;
            r_in_ready  <= 1'b1;
            r_out_valid <= 1'b0;
        end else begin
            r_state     <= w_state_next;
            r_in_ready  <= (w_state_next == ST_IDLE);
            r_out_valid <= (w_state_next == ST_DONE);
        end
    end

    // Operand capture, chunk iteration and result/flag registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_a     <= {WIDTH{1'b0}};
            r_b     <= {WIDTH{1'b0}};
            r_res   <= {WIDTH{1'b0}};
            r_carry <= 1'b0;
            r_idx   <= {IDXW{1'b0}};
            r_s     <= {WIDTH{1'b0}};
            r_cout  <= 1'b0;
            r_ovf   <= 1'b0;
            r_zero  <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (w_accept) begin
                        r_a     <= i_a;
                        r_b     <= i_b ^ {WIDTH{i_mode}};
                        r_carry <= i_mode;
                        r_idx   <= {IDXW{1'b0}};
                        r_res   <= {WIDTH{1'b0}};
                    end
                end
                ST_RUN: begin
                    r_res   <= w_res_next;
                    r_carry <= w_chunk_cout;
                    if (w_last) begin
                        r_idx  <= {IDXW{1'b0}};
                        r_s    <= w_s_final;
                        r_cout <= w_chunk_cout;
                        r_ovf  <= w_ovf_final;
                        r_zero <= ~|w_s_final;
                    end else begin
                        r_idx <= r_idx + IDXW'(1);
                    end
                end
                ST_DONE: begin
                    r_idx <= {IDXW{1'b0}};
                end
                default: begin
                    r_idx <= {IDXW{1'b0}};
                end
            endcase
        end
    end

    assign o_in_ready  = r_in_ready;
    assign o_out_valid = r_out_valid;
    assign o_s         = r_s;
    assign o_cout      = r_cout;
    assign o_ovf       = r_ovf;
    assign o_zero      = r_zero;

endmodule
